// File: rtl/fifo_rr_ctrl.sv
// Round-robin write arbiter and read sequencer for a flagless FIFO. Keeps a shadow
// occupancy count and a source-tag ring that runs in lockstep with the FIFO's pointers.
module fifo_rr_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int NREQ  = 4,
    localparam int SW = $clog2(NREQ),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  fifo_write_o,
    output logic [WIDTH-1:0]      fifo_data_in_o,
    output logic                  fifo_read_o,
    input  logic [WIDTH-1:0]      fifo_data_out_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WIDTH-1:0]      out_data_o,
    output logic [SW-1:0]         out_src_o,
    output logic [LW-1:0]         level_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  prio_o,
    output logic [SW-1:0]         last_o
);
    localparam int PW = $clog2(DEPTH);

    // Handshakes: a producer word moves on the edge where req_valid_i[i] && req_ready_o[i];
    // a consumer word moves on the edge where out_valid_o && out_ready_i.

    logic [LW-1:0] level_q, level_d;
    logic          prio_q, prio_d;
    logic [SW-1:0] last_q, last_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_src_q, out_src_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [SW-1:0] tag_q [DEPTH];

    logic [SW-1:0] grant_idx;
    logic [SW-1:0] cand;
    logic          any_req;
    logic          full, empty;
    logic          want_wr, want_rd, conflict;
    logic          wr_win, rd_win;

    // Search starts just past the last winner so every producer gets a turn.
    always_comb begin
        grant_idx = last_q;
        cand      = '0;
        any_req   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = SW'((int'(last_q) + k) % NREQ);
            if (!any_req && req_valid_i[cand]) begin
                grant_idx = cand;
                any_req   = 1'b1;
            end
        end
    end

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign want_wr  = any_req && !full;
    assign want_rd  = !empty && (!out_valid_q || out_ready_i);
    assign conflict = want_wr && want_rd;
    // Strobes are held off during reset so the FIFO never sees traffic while clearing.
    assign wr_win   = !reset && want_wr && (!want_rd || !prio_q);
    assign rd_win   = !reset && want_rd && (!want_wr || prio_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q     <= '0;
            prio_q      <= 1'b0;
            last_q      <= SW'(NREQ - 1);
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            level_q     <= level_d;
            prio_q      <= prio_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_win) begin
            tag_q[wr_ptr_q] <= grant_idx;
        end
    end

    always_comb begin
        level_d     = level_q;
        prio_d      = conflict ? ~prio_q : prio_q;
        last_d      = wr_win ? grant_idx : last_q;
        out_valid_d = rd_win ? 1'b1 : (out_ready_i ? 1'b0 : out_valid_q);
        out_src_d   = rd_win ? tag_q[rd_ptr_q] : out_src_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (wr_win) begin
            level_d  = level_q + LW'(1);
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end else if (rd_win) begin
            level_d  = level_q - LW'(1);
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (wr_win) begin
            req_ready_o[grant_idx] = 1'b1;
        end
        fifo_write_o   = wr_win;
        fifo_data_in_o = req_data_i[grant_idx*WIDTH +: WIDTH];
        fifo_read_o    = rd_win;
        out_valid_o    = out_valid_q;
        out_data_o     = fifo_data_out_i;
        out_src_o      = out_src_q;
        level_o        = level_q;
        full_o         = full;
        empty_o        = empty;
        prio_o         = prio_q;
        last_o         = last_q;
    end
endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Directed bench for fifo_rr_ctrl with a behavioural flagless FIFO attached to its ports.
module tb_fifo_rr_ctrl;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int LW = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_write, fifo_read;
    logic [W-1:0]    fifo_data_in, fifo_data_out;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_src, last;
    logic [LW-1:0]   level;
    logic            full, empty, prio;

    int errors = 0;
    int checks = 0;
    int seq [N];
    int drain_k;
    logic [SW+W-1:0] exp_q [$];
    logic [SW+W-1:0] sb_e;
    int sb_g;

    always #5 clk = ~clk;

    fifo_rr_ctrl #(.WIDTH(W), .DEPTH(D), .NREQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .fifo_write_o(fifo_write), .fifo_data_in_o(fifo_data_in),
        .fifo_read_o(fifo_read), .fifo_data_out_i(fifo_data_out),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_src_o(out_src), .level_o(level),
        .full_o(full), .empty_o(empty), .prio_o(prio), .last_o(last)
    );

    // Flagless FIFO: registered output, overwrites when full, returns all-ones when read empty.
    logic [W-1:0] mem [D];
    int fwp, frp, fcnt;
    always @(posedge clk) begin
        if (reset) begin
            fwp <= 0; frp <= 0; fcnt <= 0; fifo_data_out <= '0;
        end else begin
            if (fifo_write) begin
                mem[fwp] <= fifo_data_in;
                fwp <= (fwp + 1) % D;
            end
            if (fifo_read) begin
                fifo_data_out <= (fcnt == 0) ? 32'hFFFF_FFFF : mem[frp];
                frp <= (frp + 1) % D;
            end
            fcnt <= fcnt + (fifo_write ? 1 : 0) - (fifo_read ? 1 : 0);
        end
    end

    // Invariants and in-order scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            exp_q.delete();
        end else begin
            checks++;
            if (fifo_write && fifo_read) begin
                errors++; $display("FAIL both_strobes got wr=%b rd=%b want not both", fifo_write, fifo_read);
            end
            checks++;
            if (fifo_write && fcnt == D) begin
                errors++; $display("FAIL write_when_full got fifo_write=1 want 0 (fifo count %0d)", fcnt);
            end
            checks++;
            if (fifo_read && fcnt == 0) begin
                errors++; $display("FAIL read_when_empty got fifo_read=1 want 0");
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sb_underflow got word %h src %0d want none", out_data, out_src);
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({out_src, out_data} !== sb_e) begin
                        errors++; $display("FAIL sb_order got src %0d data %h want src %0d data %h",
                                           out_src, out_data, sb_e[SW+W-1:W], sb_e[W-1:0]);
                    end
                end
            end
            if (fifo_write) begin
                sb_g = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) sb_g = i;
                checks++;
                if (fifo_data_in !== req_data[sb_g*W +: W]) begin
                    errors++; $display("FAIL wr_data got %h want %h", fifo_data_in, req_data[sb_g*W +: W]);
                end
                exp_q.push_back({SW'(sb_g), req_data[sb_g*W +: W]});
            end
        end
    end

    function automatic logic [W-1:0] word(input int p, input int s);
        word = 32'hA000_0000 | (W'(p) << 24) | W'(s);
    endfunction

    task automatic load_data();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = word(i, seq[i]);
    endtask

    task automatic clear_seq();
        for (int i = 0; i < N; i++) seq[i] = 0;
        load_data();
    endtask

    // Moves to the next cycle; granted producers present their next word.
    task automatic advance();
        logic [N-1:0] g;
        g = req_ready;
        @(negedge clk);
        for (int i = 0; i < N; i++) if (g[i]) seq[i]++;
        load_data();
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", empty); end
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL rst_out_src got %0d want 0", out_src); end
        checks++; if (prio !== 1'b0) begin errors++; $display("FAIL rst_prio got %b want 0", prio); end
        checks++; if (last !== 2'd3) begin errors++; $display("FAIL rst_last got %0d want 3", last); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
        checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL rst_fifo_read got %b want 0", fifo_read); end
        @(negedge clk);
    endtask

    task automatic test_single();
        req_data[0 +: W] = 32'hA5A5_0001; req_valid = 4'b0001; out_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
        checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL single_write got %b want 1", fifo_write); end
        checks++; if (fifo_data_in !== 32'hA5A5_0001) begin errors++; $display("FAIL single_din got %h want a5a50001", fifo_data_in); end
        @(negedge clk); req_valid = '0;
        #1;
        checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL single_read got %b want 1", fifo_read); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level1 got %0d want 1", level); end
        @(negedge clk); out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_out_data got %h want a5a50001", out_data); end
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL single_out_src got %0d want 0", out_src); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_level0 got %0d want 0", level); end
        @(negedge clk); out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b want 0", out_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", empty); end
        @(negedge clk);
    endtask

    // Consumer stalled: two writes, one read (conflict alternation), then writes until full.
    task automatic test_round_robin();
        int exp_g, nwr, nrd;
        logic [N-1:0] expv;
        do_reset();
        clear_seq();
        req_valid = 4'b1111; out_ready = 1'b0;
        exp_g = 0; nwr = 0; nrd = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (fifo_write) begin
                expv = N'(1) << exp_g;
                checks++;
                if (req_ready !== expv) begin errors++; $display("FAIL rr_grant got %b want %b", req_ready, expv); end
                exp_g = (exp_g + 1) % N;
                nwr++;
            end
            if (fifo_read) nrd++;
            advance();
        end
        #1;
        checks++; if (nwr != 17) begin errors++; $display("FAIL rr_writes got %0d want 17", nwr); end
        checks++; if (nrd != 1) begin errors++; $display("FAIL rr_reads got %0d want 1", nrd); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL rr_full got %b want 1", full); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL rr_level got %0d want 16", level); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_ready_full got %b want 0000", req_ready); end
        checks++; if (out_data !== word(0, 0)) begin errors++; $display("FAIL rr_head got %h want %h", out_data, word(0, 0)); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        req_valid = '0; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== word(0, 0) || out_src !== 2'd0 || fifo_read !== 1'b0) begin
                errors++; $display("FAIL bp_hold got v=%b d=%h s=%0d rd=%b want v=1 d=%h s=0 rd=0",
                                   out_valid, out_data, out_src, fifo_read, word(0, 0));
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", fifo_read); end
        drain_k = 1;
        @(negedge clk);
    endtask

    task automatic test_drain();
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while (drain_k < 17 && cyc < 40) begin
            #1;
            if (out_valid) begin
                checks++;
                if (out_src !== SW'(drain_k % N) || out_data !== word(drain_k % N, drain_k / N) || out_data === 32'hFFFF_FFFF) begin
                    errors++; $display("FAIL drain_word%0d got s=%0d d=%h want s=%0d d=%h", drain_k,
                                       out_src, out_data, drain_k % N, word(drain_k % N, drain_k / N));
                end
                drain_k++;
            end
            cyc++;
            @(negedge clk);
        end
        checks++; if (drain_k != 17) begin errors++; $display("FAIL drain_count got %0d want 17", drain_k); end
        checks++; if (cyc != 16) begin errors++; $display("FAIL drain_rate got %0d cycles want 16", cyc); end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || empty !== 1'b1 || level !== 5'd0 || fifo_read !== 1'b0) begin
                errors++; $display("FAIL drain_idle got v=%b e=%b l=%0d rd=%b want 0 1 0 0", out_valid, empty, level, fifo_read);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    // Fill to level 8 with the consumer stalled, then open the consumer under full contention.
    task automatic test_contention();
        do_reset();
        clear_seq();
        req_valid = 4'b1111; out_ready = 1'b0;
        repeat (10) begin #1; advance(); end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (fifo_write !== (i % 2 == 0) || fifo_read !== (i % 2 == 1)) begin
                errors++; $display("FAIL cont_alt%0d got wr=%b rd=%b want wr=%b rd=%b", i,
                                   fifo_write, fifo_read, i % 2 == 0, i % 2 == 1);
            end
            checks++;
            if (level !== LW'(8 + (i % 2))) begin
                errors++; $display("FAIL cont_level%0d got %0d want %0d", i, level, 8 + (i % 2));
            end
            advance();
        end
        req_valid = '0; out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_seq();
        req_valid = 4'b1111; out_ready = 1'b0;
        repeat (11) begin #1; advance(); end
        reset = 1'b1; req_valid = '0;
        #1;
        checks++; if (level !== 5'd9) begin errors++; $display("FAIL mid_pre_level got %0d want 9", level); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
        checks++; if (last !== 2'd1) begin errors++; $display("FAIL mid_pre_last got %0d want 1", last); end
        @(negedge clk); reset = 1'b0;
        #1;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_level got %0d want 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", out_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b want 0000", req_ready); end
        checks++; if (prio !== 1'b0) begin errors++; $display("FAIL mid_prio got %b want 0", prio); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", empty); end
        @(negedge clk); req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
        checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL mid_first_write got %b want 1", fifo_write); end
        advance();
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_contention();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish before 100000");
        $fatal(1, "simulation time limit");
    end
endmodule
